// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, funct3 encodings and fault codes for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] FLT_NONE       = 2'd0;
  localparam logic [1:0] FLT_MISALIGNED = 2'd1;
  localparam logic [1:0] FLT_ILLEGAL    = 2'd2;
endpackage

// File: rtl/lsu_align_chk.sv
// lsu_align_chk: combinational funct3 legality and address alignment check
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  input  logic [1:0] addr,
  output logic       misaligned,
  output logic       illegal
);
  assign illegal = is_store ? (funct3 > F3_W)
                            : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  // alignment only matters once the size encoding is known to be legal
  assign misaligned = !illegal && ((funct3[1:0] == F3_H[1:0] && addr[0]) ||
                                   (funct3[1:0] == F3_W[1:0] && addr != 2'b00));
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit driving a comb-read/sync-write data memory, one request per two cycles.
// Optional LSU_PERF_CNT_EN adds load/store/fault event counters.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [RD_WIDTH-1:0]   req_rd,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RD_WIDTH-1:0]   rsp_rd,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_misaligned,
  output logic                  rsp_illegal
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           load_cnt,
  output logic [31:0]           store_cnt,
  output logic [31:0]           fault_cnt
`endif
);
  state_t              state;
  logic                is_store_q;
  logic [RD_WIDTH-1:0] rd_q;
  logic                misaligned;
  logic                illegal;
  logic                fault;
  logic                accept;
  lsu_align_chk u_chk (
    .funct3    (mem_funct3),
    .is_store  (is_store_q),
    .addr      (mem_addr[1:0]),
    .misaligned(misaligned),
    .illegal   (illegal)
  );
  assign fault     = misaligned | illegal;
  assign req_ready = state == IDLE || (state == RESP && rsp_ready);
  assign rsp_valid = state == RESP;
  assign accept    = req_valid && req_ready;
  // reset gates the write combinationally so an aborted access never reaches memory
  assign mem_wr_en = state == ACCESS && is_store_q && !fault && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      is_store_q     <= 1'b0;
      rd_q           <= '0;
      mem_funct3     <= '0;
      mem_addr       <= '0;
      mem_wr_data    <= '0;
      rsp_rd         <= '0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
    end else if (accept) begin
      state       <= ACCESS;
      is_store_q  <= req_is_store;
      rd_q        <= req_rd;
      mem_funct3  <= req_funct3;
      mem_addr    <= req_addr;
      mem_wr_data <= req_wdata;
    end else if (state == ACCESS) begin
      state          <= RESP;
      rsp_rd         <= (is_store_q || fault) ? '0 : rd_q;
      rsp_data       <= (is_store_q || fault) ? '0 : mem_rd_data;
      rsp_misaligned <= misaligned;
      rsp_illegal    <= illegal;
    end else if (state == RESP && rsp_ready) begin
      state <= IDLE;
    end
  end
`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      fault_cnt <= '0;
    end else if (state == ACCESS) begin
      load_cnt  <= load_cnt + 32'(!is_store_q && !fault);
      store_cnt <= store_cnt + 32'(is_store_q && !fault);
      fault_cnt <= fault_cnt + 32'(fault);
    end
  end
`endif
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench with a byte-addressable memory model
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  logic        rsp_illegal;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt, fault_cnt;
`endif
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] a0, a1, a2, a3;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_wr_en(mem_wr_en),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned),
    .rsp_illegal(rsp_illegal)
`ifdef LSU_PERF_CNT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  mem_rd_data = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b010:  mem_rd_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b100:  mem_rd_data = {24'h0, mem[a0]};
      3'b101:  mem_rd_data = {16'h0, mem[a1], mem[a0]};
      default: mem_rd_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[a0] <= mem_wr_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[a1] <= mem_wr_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[a2] <= mem_wr_data[23:16];
        mem[a3] <= mem_wr_data[31:24];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // one full request with rsp_ready held high; lat = negedges from accept until rsp_valid
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] rd, output logic [31:0] d, output logic [4:0] ro,
                     output logic mis, output logic ill, output int wr, output int lat);
    wr = 0;
    @(negedge clk);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (lat = 1; lat < 10 && !rsp_valid; lat++) begin
      wr += int'(mem_wr_en);
      @(negedge clk);
    end
    wr += int'(mem_wr_en);
    d = rsp_data; ro = rsp_rd; mis = rsp_misaligned; ill = rsp_illegal;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", mem_wr_en); end
    checks++; if ({mem_addr, mem_wr_data, mem_funct3} !== 67'h0) begin failures++; $display("FAIL rst_mem got=%h/%h/%h exp=0", mem_addr, mem_wr_data, mem_funct3); end
    checks++; if ({rsp_data, rsp_rd, rsp_misaligned, rsp_illegal} !== 39'h0) begin failures++; $display("FAIL rst_rsp got=%h/%h/%b/%b exp=0", rsp_data, rsp_rd, rsp_misaligned, rsp_illegal); end
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic [4:0] r; logic m, il; int wr, lat;
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd7, d, r, m, il, wr, lat);
    checks++; if (wr !== 1) begin failures++; $display("FAIL sw_wr_cycles got=%0d exp=1", wr); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if ({d, r, m, il} !== 39'h0) begin failures++; $display("FAIL sw_rsp got=%h/%h/%b/%b exp=0", d, r, m, il); end
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, d, r, m, il, wr, lat);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", d); end
    checks++; if (r !== 5'd5) begin failures++; $display("FAIL lw_rd got=%0d exp=5", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (wr !== 0) begin failures++; $display("FAIL lw_wr_cycles got=%0d exp=0", wr); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] d; logic [4:0] r; logic m, il; int wr, lat;
    txn(1'b1, 3'b000, 32'h13, 32'h00000080, 5'd1, d, r, m, il, wr, lat);
    checks++; if (wr !== 1) begin failures++; $display("FAIL sb_wr_cycles got=%0d exp=1", wr); end
    txn(1'b0, 3'b000, 32'h13, 32'h0, 5'd8, d, r, m, il, wr, lat);
    checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", d); end
    txn(1'b0, 3'b100, 32'h13, 32'h0, 5'd9, d, r, m, il, wr, lat);
    checks++; if (d !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", d); end
    txn(1'b0, 3'b001, 32'h12, 32'h0, 5'd10, d, r, m, il, wr, lat);
    checks++; if (d !== 32'hFFFF80AD) begin failures++; $display("FAIL lh_data got=%h exp=ffff80ad", d); end
    txn(1'b0, 3'b101, 32'h12, 32'h0, 5'd11, d, r, m, il, wr, lat);
    checks++; if (d !== 32'h000080AD || r !== 5'd11) begin failures++; $display("FAIL lhu_rsp got=%h/%0d exp=000080ad/11", d, r); end
  endtask

  task automatic test_faults();
    logic [31:0] d; logic [4:0] r; logic m, il; int wr, lat;
    txn(1'b1, 3'b010, 32'h12, 32'h11111111, 5'd6, d, r, m, il, wr, lat);
    checks++; if (wr !== 0) begin failures++; $display("FAIL sw_mis_wr got=%0d exp=0", wr); end
    checks++; if ({m, il, r} !== {1'b1, 1'b0, 5'd0}) begin failures++; $display("FAIL sw_mis_flags got=%b/%b/%0d exp=1/0/0", m, il, r); end
    txn(1'b0, 3'b001, 32'h11, 32'h0, 5'd3, d, r, m, il, wr, lat);
    checks++; if ({m, il, d, r} !== {1'b1, 1'b0, 32'h0, 5'd0}) begin failures++; $display("FAIL lh_mis got=%b/%b/%h/%0d exp=1/0/0/0", m, il, d, r); end
    txn(1'b0, 3'b011, 32'h10, 32'h0, 5'd4, d, r, m, il, wr, lat);
    checks++; if ({m, il, d, r} !== {1'b0, 1'b1, 32'h0, 5'd0}) begin failures++; $display("FAIL ld_f3_011 got=%b/%b/%h/%0d exp=0/1/0/0", m, il, d, r); end
    txn(1'b1, 3'b100, 32'h10, 32'h22222222, 5'd4, d, r, m, il, wr, lat);
    checks++; if ({m, il, wr} !== {1'b0, 1'b1, 32'd0}) begin failures++; $display("FAIL st_f3_100 got=%b/%b/%0d exp=0/1/0", m, il, wr); end
    txn(1'b0, 3'b110, 32'h11, 32'h0, 5'd4, d, r, m, il, wr, lat);
    checks++; if ({m, il} !== 2'b01) begin failures++; $display("FAIL ld_f3_110_prio got=%b/%b exp=0/1", m, il); end
    txn(1'b0, 3'b010, 32'h12, 32'h0, 5'd4, d, r, m, il, wr, lat);
    checks++; if ({m, il, d} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("FAIL lw_mis got=%b/%b/%h exp=1/0/0", m, il, d); end
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, d, r, m, il, wr, lat);
    checks++; if (d !== 32'h80ADBEEF) begin failures++; $display("FAIL mem_untouched got=%h exp=80adbeef", d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0; req_rd = 5'd1;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_access_ready got=%b exp=0", req_ready); end
    req_funct3 = 3'b100; req_addr = 32'h13; req_rd = 5'd2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, req_ready, mem_wr_en} !== 3'b100) begin failures++; $display("FAIL bp_hold_ctl got=%b%b%b exp=100", rsp_valid, req_ready, mem_wr_en); end
      checks++; if (rsp_data !== 32'h80ADBEEF || rsp_rd !== 5'd1) begin failures++; $display("FAIL bp_hold_rsp got=%h/%0d exp=80adbeef/1", rsp_data, rsp_rd); end
      checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL bp_no_access got=%h exp=10", mem_addr); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || mem_addr !== 32'h13) begin failures++; $display("FAIL b2b_access_b got=%b/%h exp=0/13", rsp_valid, mem_addr); end
    req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'h5A; req_rd = 5'd9;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h80 || rsp_rd !== 5'd2) begin failures++; $display("FAIL b2b_rsp_b got=%b/%h/%0d exp=1/80/2", rsp_valid, rsp_data, rsp_rd); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 32'h14 || rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_access_c got=%b/%h/%b exp=1/14/0", mem_wr_en, mem_addr, rsp_valid); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_rd !== 5'd0 || mem[8'h14] !== 8'h5A) begin failures++; $display("FAIL b2b_rsp_c got=%b/%0d/%h exp=1/0/5a", rsp_valid, rsp_rd, mem[8'h14]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [4:0] r; logic m, il; int wr, lat;
    @(negedge clk);
    req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234; req_rd = 5'd3;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%b exp=0", mem_wr_en); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rmid_state got=%b/%b exp=0/1", rsp_valid, req_ready); end
    checks++; if ({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} !== 32'h0) begin failures++; $display("FAIL rmid_mem got=%h exp=0", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}); end
    txn(1'b0, 3'b010, 32'h20, 32'h0, 5'd12, d, r, m, il, wr, lat);
    checks++; if (d !== 32'h0 || r !== 5'd12 || lat !== 2) begin failures++; $display("FAIL rmid_reload got=%h/%0d/%0d exp=0/12/2", d, r, lat); end
  endtask

  task automatic test_perf();
    logic [31:0] d; logic [4:0] r; logic m, il; int wr, lat;
    pulse_reset();
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5'd1, d, r, m, il, wr, lat);
    txn(1'b0, 3'b000, 32'h13, 32'h0, 5'd2, d, r, m, il, wr, lat);
    txn(1'b0, 3'b100, 32'h13, 32'h0, 5'd3, d, r, m, il, wr, lat);
    txn(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd4, d, r, m, il, wr, lat);
    txn(1'b1, 3'b000, 32'h31, 32'h77, 5'd5, d, r, m, il, wr, lat);
    txn(1'b0, 3'b001, 32'h11, 32'h0, 5'd6, d, r, m, il, wr, lat);
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL perf_mis got=%b exp=1", m); end
    checks++; if ({mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} !== 32'hCAFE770D) begin failures++; $display("FAIL perf_mem got=%h exp=cafe770d", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}); end
`ifdef LSU_PERF_CNT_EN
    checks++; if (load_cnt !== 32'd3) begin failures++; $display("FAIL load_cnt got=%0d exp=3", load_cnt); end
    checks++; if (store_cnt !== 32'd2) begin failures++; $display("FAIL store_cnt got=%0d exp=2", store_cnt); end
    checks++; if (fault_cnt !== 32'd1) begin failures++; $display("FAIL fault_cnt got=%0d exp=1", fault_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_sign();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
